store_packer: RTL and testbench
===============================

// Module: store_packer
// PURPOSE
//  Narrows and aligns store data for the data-memory port. This is the write-side
//  counterpart of immediate/load widening.
//  Takes a 32-bit register value, a byte address and an access size (SB/SH/SW).
//  Places the value in the correct little-endian byte lanes, generates byte enables
//  and queues the result in a small FIFO toward data memory.
//  Misaligned stores are rejected, with a registered exception pulse to the control unit.
// PARAMETERS
//  DEPTH   2   store-queue entries; power of 2, >=2
// PORTS
//  clk            in   1   system clock; all state updates on rising edge
//  rst            in   1   reset, asynchronous, active-high
//  flush          in   1   synchronous: discard all queued stores (exception/eret)
//  in_valid       in   1   store request present
//  in_ready       out  1   queue can accept a request this cycle
//  in_addr        in   32  byte address of store
//  in_data        in   32  rt register value; low bits hold the stored byte/half
//  in_size        in   2   store_size_e: 0=BYTE, 1=HALF, 2=WORD, 3=reserved
//  out_valid      out  1   head entry valid toward memory
//  out_ready      in   1   memory accepts head entry
//  out_addr       out  32  word address, in_addr[31:2] and 2'b00
//  out_wdata      out  32  lane-aligned write data
//  out_be         out  4   byte enables; be[i] covers wdata[8i+7:8i]
//  misalign       out  1   one-cycle pulse: a misaligned request was consumed
//  misalign_addr  out  32  faulting in_addr; held until the next misalign
// BEHAVIOUR
//  Reset: queue empty, out_valid=0, out_addr/out_wdata/out_be=0, misalign=0,
//   misalign_addr=0. Reset mid-transfer drops all entries with no output glitch
//   beyond the async clear.
//  Handshake: a transfer happens on an edge where valid&&ready.
//   out_* are stable while out_valid && !out_ready.
//   in_ready = (count < DEPTH) && !flush. It does not depend on out_ready, so a
//   full queue does not pass through in the same cycle.
//  Packing, with o=in_addr[1:0]:
//   BYTE: wdata = {4{in_data[7:0]}}, be = 4'b0001 << o.
//   HALF: wdata = {2{in_data[15:0]}}, be = o[1] ? 4'b1100 : 4'b0011.
//   WORD: wdata = in_data, be = 4'b1111.
//   Unused lanes carry replicated data; memory must honour be.
//  Misalignment: HALF with o[0]=1, WORD with o!=0, or size=3.
//   The request is still consumed (in_ready applies) but is never enqueued.
//   Next cycle: misalign=1 and misalign_addr=in_addr.
//  Latency: an accepted aligned store appears at out_* on the following cycle when
//   the queue was empty. Otherwise it waits behind older entries, strict FIFO order.
//  Simultaneous push and pop: count is unchanged and both pointers advance.
//   Pointers wrap modulo DEPTH.
//  flush: count=0 and pointers=0 on the edge. A concurrent push is dropped and
//   in_ready is already 0. A concurrent out handshake is still counted as delivered
//   by memory. misalign is not affected.
//  Full (count==DEPTH): in_ready=0. Empty: out_valid=0, out_* hold their last values.
// STRUCTURE
//  Shared package cpu_pkg: typedef enum logic [1:0] store_size_e {SZ_BYTE,SZ_HALF,
//   SZ_WORD,SZ_RSVD}; typedef struct packed {addr[31:2]; wdata[31:0]; be[3:0];}
//   mem_wr_t.
//  Sub-module store_lane_pack: purely combinational. Maps addr, data and size to
//   mem_wr_t plus a misaligned flag.
//  Top level: a DEPTH-entry mem_wr_t ring buffer, with wr_ptr, rd_ptr and a
//   $clog2(DEPTH)+1-bit count, plus the misalign registers.
// TESTING
//  1 SB addr=0x1003 data=0x123456AB, out_ready=1: next cycle out_addr=0x1000,
//    be=4'b1000, wdata=0xABABABAB.
//  2 SH addr=0x2002 data=0xBEEFCAFE: be=4'b1100, wdata=0xCAFECAFE.
//    SW addr=0x2004: be=4'b1111, wdata=data.
//  3 SH addr=0x3001, then SW addr=0x3006, then size=3 addr=0x3000: each gives
//    misalign=1 for one cycle with misalign_addr = 0x3001, 0x3006, 0x3000;
//    out_valid stays 0.
//  4 out_ready=0 and three back-to-back SW: first two accepted, in_ready=0 on the
//    third. Raise out_ready: entries drain in order and the third is accepted on
//    the first pop+1 cycle.
//  5 Queue full with out_ready=1 and in_valid=1 held: push/pop each cycle once
//    count<DEPTH; data stays in order across pointer wrap.
//  6 Two entries queued, assert flush with in_valid=1: next cycle out_valid=0 and
//    no stale entry ever appears. Assert rst mid-stream: all outputs read 0
//    immediately, before any clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types for the memory write path.
package cpu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } store_size_e;

  typedef struct packed {
    logic [31:2] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_wr_t;

endpackage

// File: rtl/store_lane_pack.sv
// Combinational store alignment: places data in little-endian byte lanes
// and builds byte enables; flags misaligned or reserved-size requests.
module store_lane_pack
  import cpu_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  store_size_e size,
  output mem_wr_t     wr,
  output logic        misaligned
);

  logic [1:0] o;
  assign o = addr[1:0];

  always_comb begin
    wr.addr    = addr[31:2];
    wr.wdata   = data;
    wr.be      = 4'b0000;
    misaligned = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        wr.wdata = {4{data[7:0]}};
        wr.be    = 4'b0001 << o;
      end
      SZ_HALF: begin
        wr.wdata   = {2{data[15:0]}};
        wr.be      = o[1] ? 4'b1100 : 4'b0011;
        misaligned = o[0];
      end
      SZ_WORD: begin
        wr.be      = 4'b1111;
        misaligned = (o != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_packer.sv
// Store data packer with a small FIFO toward data memory. The head entry is
// kept in a register so out_* hold their last values when the queue drains.
module store_packer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_size,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_be,
  output logic        misalign,
  output logic [31:0] misalign_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mem_wr_t       mem [DEPTH];
  mem_wr_t       pk, head, head_n;
  logic          mis, acc, push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] count, count_n;

  store_lane_pack u_pack (
    .addr      (in_addr),
    .data      (in_data),
    .size      (store_size_e'(in_size)),
    .wr        (pk),
    .misaligned(mis)
  );

  assign in_ready  = (count < CW'(DEPTH)) && !flush;
  assign out_valid = (count != '0);
  assign acc       = in_valid && in_ready;
  assign push      = acc && !mis;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_n  = count + CW'(push) - CW'(pop);
    wr_ptr_n = wr_ptr + PW'(push);
    rd_ptr_n = rd_ptr + PW'(pop);
    if (flush) begin
      count_n  = '0;
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end
    head_n = head;
    // New head is the incoming entry only when it lands in the slot being read.
    if (count_n != '0)
      head_n = (push && (wr_ptr == rd_ptr_n)) ? pk : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      head          <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      count    <= count_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      head     <= head_n;
      misalign <= acc && mis;
      if (acc && mis) misalign_addr <= in_addr;
    end
  end

  assign out_addr  = {head.addr, 2'b00};
  assign out_wdata = head.wdata;
  assign out_be    = head.be;

endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer: packing, misalign, backpressure, wrap, flush, reset.
module tb_store_packer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, misalign;
  logic [31:0] in_addr, in_data, out_addr, out_wdata, misalign_addr;
  logic [1:0]  in_size;
  logic [3:0]  out_be;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  store_packer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_be(out_be),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    in_valid = v;
    in_size  = sz;
    in_addr  = a;
    in_data  = d;
  endtask

  initial begin
    int  nxt;
    logic acc;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_out_wdata", out_wdata, 32'h0);
    chk("rst_out_be", {28'b0, out_be}, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_misalign_addr", misalign_addr, 32'h0);
    @(negedge clk) rst = 1'b0;
    step();
    chk("idle_in_ready", {31'b0, in_ready}, 32'h1);

    // SB to lane 3
    out_ready = 1'b1;
    drive(1'b1, 2'd0, 32'h0000_1003, 32'h1234_56AB);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    chk("sb_valid", {31'b0, out_valid}, 32'h1);
    chk("sb_addr", out_addr, 32'h0000_1000);
    chk("sb_be", {28'b0, out_be}, 32'h8);
    chk("sb_wdata", out_wdata, 32'hABAB_ABAB);
    step();
    chk("sb_drained", {31'b0, out_valid}, 32'h0);
    chk("empty_hold_be", {28'b0, out_be}, 32'h8);

    // SH upper half then SW, pushed while SH pops
    drive(1'b1, 2'd1, 32'h0000_2002, 32'hBEEF_CAFE);
    step();
    chk("sh_be", {28'b0, out_be}, 32'hC);
    chk("sh_wdata", out_wdata, 32'hCAFE_CAFE);
    chk("sh_addr", out_addr, 32'h0000_2000);
    drive(1'b1, 2'd2, 32'h0000_2004, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    chk("sw_be", {28'b0, out_be}, 32'hF);
    chk("sw_wdata", out_wdata, 32'hDEAD_BEEF);
    chk("sw_addr", out_addr, 32'h0000_2004);
    step();
    chk("sw_drained", {31'b0, out_valid}, 32'h0);

    // misaligned requests, back to back
    drive(1'b1, 2'd1, 32'h0000_3001, 32'h1111_1111);
    step();
    drive(1'b1, 2'd2, 32'h0000_3006, 32'h2222_2222);
    chk("mis_sh_pulse", {31'b0, misalign}, 32'h1);
    chk("mis_sh_addr", misalign_addr, 32'h0000_3001);
    chk("mis_sh_noq", {31'b0, out_valid}, 32'h0);
    step();
    drive(1'b1, 2'd3, 32'h0000_3000, 32'h3333_3333);
    chk("mis_sw_pulse", {31'b0, misalign}, 32'h1);
    chk("mis_sw_addr", misalign_addr, 32'h0000_3006);
    chk("mis_sw_noq", {31'b0, out_valid}, 32'h0);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    chk("mis_rsvd_pulse", {31'b0, misalign}, 32'h1);
    chk("mis_rsvd_addr", misalign_addr, 32'h0000_3000);
    chk("mis_rsvd_noq", {31'b0, out_valid}, 32'h0);
    step();
    chk("mis_pulse_end", {31'b0, misalign}, 32'h0);
    chk("mis_addr_hold", misalign_addr, 32'h0000_3000);

    // backpressure: two accepted, third stalls until first pop
    out_ready = 1'b0;
    drive(1'b1, 2'd2, 32'h0000_4000, 32'hA0A0_A0A0);
    chk("bp_rdy0", {31'b0, in_ready}, 32'h1);
    step();
    drive(1'b1, 2'd2, 32'h0000_4004, 32'hA1A1_A1A1);
    chk("bp_rdy1", {31'b0, in_ready}, 32'h1);
    chk("bp_head0", out_addr, 32'h0000_4000);
    step();
    drive(1'b1, 2'd2, 32'h0000_4008, 32'hA2A2_A2A2);
    chk("bp_full", {31'b0, in_ready}, 32'h0);
    step();
    chk("bp_stable", out_wdata, 32'hA0A0_A0A0);
    chk("bp_full_hold", {31'b0, in_ready}, 32'h0);
    out_ready = 1'b1;
    #1;
    chk("bp_no_passthru", {31'b0, in_ready}, 32'h0);
    step();
    chk("bp_head1", out_wdata, 32'hA1A1_A1A1);
    chk("bp_rdy_after_pop", {31'b0, in_ready}, 32'h1);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    chk("bp_head2", out_wdata, 32'hA2A2_A2A2);
    chk("bp_head2_addr", out_addr, 32'h0000_4008);
    step();
    chk("bp_drained", {31'b0, out_valid}, 32'h0);

    // full queue streaming across pointer wrap
    out_ready = 1'b0;
    drive(1'b1, 2'd2, 32'h0000_5000, 32'h0000_00B0);
    step();
    drive(1'b1, 2'd2, 32'h0000_5004, 32'h0000_00B1);
    step();
    nxt = 2;
    drive(1'b1, 2'd2, 32'h0000_5008, 32'h0000_00B2);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("wrap_valid%0d", k), {31'b0, out_valid}, 32'h1);
      chk($sformatf("wrap_head%0d", k), out_wdata, 32'hB0 + k);
      chk($sformatf("wrap_rdy%0d", k), {31'b0, in_ready}, (k == 0) ? 32'h0 : 32'h1);
      acc = in_valid && in_ready;
      step();
      if (acc) nxt++;
      drive(nxt <= 5, 2'd2, 32'h0000_5000 + 4 * nxt, 32'hB0 + nxt);
    end
    chk("wrap_drained", {31'b0, out_valid}, 32'h0);

    // flush with two entries queued and a concurrent push
    out_ready = 1'b0;
    drive(1'b1, 2'd2, 32'h0000_6000, 32'hC0C0_C0C0);
    step();
    drive(1'b1, 2'd2, 32'h0000_6004, 32'hC1C1_C1C1);
    step();
    flush = 1'b1;
    drive(1'b1, 2'd2, 32'h0000_6008, 32'hC2C2_C2C2);
    #1;
    chk("flush_rdy", {31'b0, in_ready}, 32'h0);
    step();
    flush = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    out_ready = 1'b1;
    chk("flush_empty", {31'b0, out_valid}, 32'h0);
    step();
    chk("flush_no_stale", {31'b0, out_valid}, 32'h0);
    drive(1'b1, 2'd2, 32'h0000_7000, 32'hD0D0_D0D0);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    chk("post_flush_valid", {31'b0, out_valid}, 32'h1);
    chk("post_flush_data", out_wdata, 32'hD0D0_D0D0);
    step();

    // async reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 32'h0000_7001, 32'h0000_00D1);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_addr", out_addr, 32'h0);
    chk("arst_wdata", out_wdata, 32'h0);
    chk("arst_be", {28'b0, out_be}, 32'h0);
    chk("arst_mis_addr", misalign_addr, 32'h0);
    @(negedge clk) rst = 1'b0;
    step();
    chk("post_rst_empty", {31'b0, out_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
